// File: rtl/fpga_cfg_loader_pkg.sv
// Shared encodings for the configuration-chain loader.
package fpga_cfg_loader_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_SETUP = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Which pass over the chains is in progress.
  typedef enum logic {
    PASS_LOAD   = 1'b0,
    PASS_VERIFY = 1'b1
  } pass_e;

endpackage

// File: rtl/fpga_cfg_loader_phase_timer.sv
// DIV-cycle down-counter timing one prog_clk phase (SETUP low or HIGH).
// expire_o is high in the last cycle of the phase; load_i restarts it.
module fpga_cfg_loader_phase_timer #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int            TW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(DIV - 1);

  logic [TW-1:0] cnt_q;

  // Reload at phase entry, then count down and park at zero.
  always_ff @(posedge clk_i) begin
    if (reset_i)             cnt_q <= '0;
    else if (load_i)         cnt_q <= RELOAD;
    else if (cnt_q != '0)    cnt_q <= cnt_q - TW'(1);
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/fpga_cfg_loader.sv
// Configuration-chain controller: shifts a valid/ready bitstream into
// NUM_CHAINS parallel ccff chains with a divided prog_clk, holds the fabric
// in reset while loading, and optionally checks ccff_tail on a replay pass.
module fpga_cfg_loader
  import fpga_cfg_loader_pkg::*;
#(
  parameter int NUM_CHAINS = 1,
  parameter int CHAIN_LEN  = 1024,
  parameter int DIV        = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [NUM_CHAINS-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  prog_clk_o,
  output logic [NUM_CHAINS-1:0] ccff_head_o,
  input  logic [NUM_CHAINS-1:0] ccff_tail_i,
  output logic                  fpga_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [NUM_CHAINS-1:0] err_o
);

  localparam int               CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

  state_e                  state_q;
  pass_e                   pass_q;
  logic                    mode_q;
  logic [CNT_W-1:0]        bitcnt_q, bitcnt_d;
  logic                    prog_clk_q, in_ready_q, busy_q, done_q, fpga_rst_q;
  logic [NUM_CHAINS-1:0]   head_q, err_q;
  logic                    phase_load, phase_exp;

  // Timer restarts on bit acceptance (SETUP entry) and on SETUP->HIGH.
  assign phase_load = ((state_q == ST_WAIT)  && in_valid_i) ||
                      ((state_q == ST_SETUP) && phase_exp);

  fpga_cfg_loader_phase_timer #(.DIV(DIV)) u_phase (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (phase_load),
    .expire_o (phase_exp)
  );

  // Count the bit being completed; compared before it is stored so it never wraps.
  assign bitcnt_d = bitcnt_q + CNT_W'(1);

  // Control FSM; every output is a register updated with the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      pass_q     <= PASS_LOAD;
      mode_q     <= 1'b0;
      bitcnt_q   <= '0;
      prog_clk_q <= 1'b0;
      head_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      fpga_rst_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            err_q      <= '0;
            done_q     <= 1'b0;
            mode_q     <= mode_i;
            pass_q     <= PASS_LOAD;
            bitcnt_q   <= '0;
            busy_q     <= 1'b1;
            fpga_rst_q <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (in_valid_i) begin
            head_q     <= in_data_i;
            in_ready_q <= 1'b0;
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (phase_exp) begin
            // Tail has settled to the bit that went in CHAIN_LEN shifts ago.
            if (pass_q == PASS_VERIFY) err_q <= err_q | (ccff_tail_i ^ head_q);
            prog_clk_q <= 1'b1;
            state_q    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (phase_exp) begin
            prog_clk_q <= 1'b0;
            if (bitcnt_d != LEN_C) begin
              bitcnt_q   <= bitcnt_d;
              in_ready_q <= 1'b1;
              state_q    <= ST_WAIT;
            end else if ((pass_q == PASS_LOAD) && mode_q) begin
              pass_q     <= PASS_VERIFY;
              bitcnt_q   <= '0;
              in_ready_q <= 1'b1;
              state_q    <= ST_WAIT;
            end else begin
              bitcnt_q   <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              fpga_rst_q <= 1'b0;
              state_q    <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign prog_clk_o  = prog_clk_q;
  assign ccff_head_o = head_q;
  assign fpga_rst_o  = fpga_rst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench: 2 chains of 8 bits, DIV=2. Chain fabric modelled as shift
// registers clocked by prog_clk; expected heads go through a scoreboard queue.
module tb_fpga_cfg_loader;

  localparam int NC = 2;
  localparam int CL = 8;
  localparam int DV = 2;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, mode, in_valid;
  logic [NC-1:0] in_data, tail;
  logic          in_ready_o, prog_clk_o, fpga_rst_o, busy_o, done_o;
  logic [NC-1:0] ccff_head_o, err_o;

  fpga_cfg_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .DIV(DV)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .mode_i      (mode),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .prog_clk_o  (prog_clk_o),
    .ccff_head_o (ccff_head_o),
    .ccff_tail_i (tail),
    .fpga_rst_o  (fpga_rst_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  // Fabric model: bit enters at [7], leaves at [0]; optional stuck-at-0 on chain1 bit 3.
  logic [7:0] ch0 = '0, ch1 = '0;
  logic       stuck = 1'b0;
  always @(posedge prog_clk_o) begin
    ch0 <= {ccff_head_o[0], ch0[7:1]};
    ch1 <= {ccff_head_o[1], ch1[7:1]};
    if (stuck) ch1[3] <= 1'b0;
  end
  assign tail = {ch1[0], ch0[0]};

  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_vec = 0, n_fail = 0;
  int         t0 = 0, pe0 = 0, pe_cnt = 0;
  logic [1:0] sb[$];
  logic [1:0] stream [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start pulse for one cycle; cycle of the pulse is cycle 1.
  task automatic do_start(input logic m);
    start = 1'b1; mode = m; t0 = cyc; pe0 = pe_cnt;
    @(negedge clk);
    start = 1'b0; mode = 1'b0;
    chk("busy_after_start", 32'(busy_o), 1);
    chk("done_cleared",     32'(done_o), 0);
    chk("err_cleared",      32'(err_o),  0);
    chk("in_ready_wait",    32'(in_ready_o), 1);
  endtask

  // Source: holds valid, optional stall before bit stall_at, optional
  // start/valid glitch in the SETUP right after bit glitch_at.
  task automatic run_pass(input int nbits, input int stall_at, input int stall_len,
                          input int glitch_at);
    for (int k = 0; k < nbits; k++) begin
      if (k == stall_at) begin
        in_valid = 1'b0;
        for (int n = 0; n < 50 && !in_ready_o; n++) @(negedge clk);
        for (int s = 0; s < stall_len; s++) begin
          chk("stall_ready", 32'(in_ready_o), 1);
          chk("stall_pclk",  32'(prog_clk_o), 0);
          @(negedge clk);
        end
      end
      in_valid = 1'b1; in_data = stream[k];
      for (int n = 0; n < 50 && !in_ready_o; n++) @(negedge clk);
      chk("in_ready", 32'(in_ready_o), 1);
      sb.push_back(stream[k]);
      @(negedge clk);
      if (k == glitch_at) begin
        chk("ready_in_setup", 32'(in_ready_o), 0);
        start = 1'b1; mode = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        chk("busy_glitch", 32'(busy_o), 1);
      end
    end
  endtask

  task automatic wait_done(input int exp_lat, input int exp_pe);
    in_valid = 1'b0;
    for (int n = 0; n < 500 && !done_o; n++) @(negedge clk);
    chk("done",         32'(done_o), 1);
    chk("done_latency", cyc - t0, exp_lat);
    chk("prog_edges",   pe_cnt - pe0, exp_pe);
    chk("fpga_rst_low", 32'(fpga_rst_o), 0);
    chk("busy_low",     32'(busy_o), 0);
    chk("pclk_idle",    32'(prog_clk_o), 0);
    chk("sb_drained",   sb.size(), 0);
  endtask

  task automatic chk_chain();
    chk("chain0", 32'(ch0), 32'h55);
    chk("chain1", 32'(ch1), 32'hAA);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < 8; k++) stream[k] = (k % 2 == 0) ? 2'b01 : 2'b10;

    // Monitor: each prog_clk rising edge must shift the next expected head.
    fork
      begin : mon
        logic prev;
        prev = 1'b0;
        forever begin
          @(negedge clk);
          if (prog_clk_o && !prev) begin
            pe_cnt++;
            chk("rst_while_shift", 32'(fpga_rst_o), 1);
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("ccff_head", 32'(ccff_head_o), 32'(sb.pop_front()));
          end
          prev = prog_clk_o;
        end
      end
    join_none

    // Reset values, and start during reset is ignored.
    repeat (3) @(negedge clk);
    chk("rst_pclk",  32'(prog_clk_o), 0);
    chk("rst_head",  32'(ccff_head_o), 0);
    chk("rst_ready", 32'(in_ready_o), 0);
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_done",  32'(done_o), 0);
    chk("rst_err",   32'(err_o), 0);
    chk("rst_frst",  32'(fpga_rst_o), 1);
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_beats_start", 32'(busy_o), 0);
    chk("idle_frst",       32'(fpga_rst_o), 1);

    // 1: load only, always valid. Start cycle = 1, done visible in cycle 8*5+2.
    do_start(1'b0);
    run_pass(8, -1, 0, -1);
    wait_done(41, 8);
    chk_chain();

    // 2: load + verify with correct replay.
    do_start(1'b1);
    run_pass(8, -1, 0, -1);
    run_pass(8, -1, 0, -1);
    wait_done(81, 16);
    chk("verify_err_ok", 32'(err_o), 0);
    chk_chain();

    // 3: stuck-at-0 on chain1 bit 3 flags chain1 only; err sticky.
    stuck = 1'b1;
    do_start(1'b1);
    run_pass(8, -1, 0, -1);
    run_pass(8, -1, 0, -1);
    wait_done(81, 16);
    chk("verify_err_stuck", 32'(err_o), 32'h2);
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'(err_o), 32'h2);
    chk("done_sticky", 32'(done_o), 1);
    stuck = 1'b0;

    // 4: 10-cycle source stall before bit 3.
    do_start(1'b0);
    run_pass(8, 3, 10, -1);
    wait_done(51, 8);
    chk_chain();

    // 5: reset during HIGH of bit 5, then reload.
    do_start(1'b0);
    run_pass(6, -1, 0, -1);
    for (int n = 0; n < 20 && !prog_clk_o; n++) @(negedge clk);
    chk("in_high", 32'(prog_clk_o), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    chk("midrst_pclk",  32'(prog_clk_o), 0);
    chk("midrst_busy",  32'(busy_o), 0);
    chk("midrst_frst",  32'(fpga_rst_o), 1);
    chk("midrst_ready", 32'(in_ready_o), 0);
    chk("midrst_head",  32'(ccff_head_o), 0);
    chk("midrst_sb",    sb.size(), 0);
    @(negedge clk);
    chk("midrst_idle", 32'(busy_o), 0);
    do_start(1'b0);
    run_pass(8, -1, 0, -1);
    wait_done(41, 8);
    chk_chain();

    // 6: start(mode=1) while busy and valid during SETUP are ignored.
    do_start(1'b0);
    run_pass(8, -1, 0, 2);
    wait_done(41, 8);
    chk("glitch_err", 32'(err_o), 0);
    chk_chain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
